// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared definitions for the sprite ROM arbiter: FSM encoding, default
// parameters and a width helper for id/beat counters.
package sprite_rom_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_ADDR_WIDTH   = 12;
  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_READ_LATENCY = 2;
  localparam int DEF_BURST_LEN    = 8;

  // Never returns less than 1 so single-entry counters still get a real bit.
  function automatic int clog2(input int value);
    int width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_tag_delay.sv
// Fixed-depth delay line for {valid, payload} tags; flush clears only the
// valid bits so stale payloads are never reported.
module tag_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];
  assign busy_o  = |valid_q;

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin burst arbiter sharing one synchronous sprite ROM between
// render units; returned data is steered by a delayed request tag.
module sprite_rom_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int BURST_LEN    = DEF_BURST_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] base_addr_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          rom_en_o,
  output logic [ADDR_WIDTH-1:0]         rom_addr_o,
  input  logic [DATA_WIDTH-1:0]         rom_data_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [NUM_REQ-1:0]            data_valid_o,
  output logic                          data_last_o,
  output logic                          busy_o
);

  localparam int ID_W   = clog2(NUM_REQ);
  localparam int BEAT_W = clog2(BURST_LEN);

  arb_state_t            state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d, id_q, id_d, sel_id, cand;
  logic [ADDR_WIDTH-1:0] base_q, base_d, rom_addr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [NUM_REQ-1:0]    gnt_d;
  logic                  rom_en_d, sel_found, beat_last;
  logic                  tag_valid, tag_last, tag_busy;
  logic [ID_W-1:0]       tag_id;
  logic [ADDR_WIDTH-1:0] base_arr [NUM_REQ];

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_base
    assign base_arr[n] = base_addr_i[n*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign beat_last = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign busy_o    = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      base_q     <= '0;
      beat_q     <= '0;
      gnt_o      <= '0;
      rom_en_o   <= 1'b0;
      rom_addr_o <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      base_q     <= base_d;
      beat_q     <= beat_d;
      gnt_o      <= gnt_d;
      rom_en_o   <= rom_en_d;
      rom_addr_o <= rom_addr_d;
    end
  end

  // Search starts at the pointer and wraps, so the most recent winner goes last.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    base_d     = base_q;
    beat_d     = beat_q;
    gnt_d      = '0;
    rom_en_d   = 1'b0;
    rom_addr_d = rom_addr_o;
    sel_found  = 1'b0;
    sel_id     = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!sel_found && req_i[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            state_d    = ISSUE;
            id_d       = sel_id;
            base_d     = base_arr[sel_id];
            beat_d     = '0;
            gnt_d      = NUM_REQ'(1) << sel_id;
            rom_en_d   = 1'b1;
            rom_addr_d = base_arr[sel_id];
            ptr_d      = (int'(sel_id) == NUM_REQ - 1) ? '0 : sel_id + 1'b1;
          end
        end
        ISSUE: begin
          if (beat_last) begin
            state_d = DRAIN;
          end else begin
            beat_d     = beat_q + 1'b1;
            rom_en_d   = 1'b1;
            rom_addr_d = base_q + ADDR_WIDTH'(beat_d);
          end
        end
        DRAIN: begin
          if (!tag_busy) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  tag_delay #(
    .DEPTH (READ_LATENCY),
    .WIDTH (ID_W + 1)
  ) u_tag_delay (
    .clk     (clk),
    .rst     (rst),
    .flush   (!en_i),
    .valid_i (rom_en_o),
    .data_i  ({id_q, rom_en_o && beat_last}),
    .valid_o (tag_valid),
    .data_o  ({tag_id, tag_last}),
    .busy_o  (tag_busy)
  );

  // data_o deliberately holds between bursts; only the qualifiers drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o       <= '0;
      data_valid_o <= '0;
      data_last_o  <= 1'b0;
    end else if (en_i && tag_valid) begin
      data_o       <= rom_data_i;
      data_valid_o <= NUM_REQ'(1) << tag_id;
      data_last_o  <= tag_last;
    end else begin
      data_valid_o <= '0;
      data_last_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: default configuration plus a
// single-beat, single-cycle-latency instance sharing clock and reset.
module tb_sprite_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [3:0]  req = '0;
  logic [47:0] base_addr = '0;
  logic [3:0]  gnt, data_valid;
  logic        rom_en, data_last, busy;
  logic [11:0] rom_addr;
  logic [15:0] rom_data, data;

  logic        m_en = 1'b1;
  logic [3:0]  m_req = '0;
  logic [47:0] m_base_addr = '0;
  logic [3:0]  m_gnt, m_data_valid;
  logic        m_rom_en, m_data_last, m_busy;
  logic [11:0] m_rom_addr;
  logic [15:0] m_rom_data, m_data;

  logic [11:0] r1 = '0, r2 = '0, m1 = '0;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [11:0] a);
    return {4'hD, a};
  endfunction

  // Behavioural ROMs: two-cycle latency for the main DUT, one for the small one.
  always @(posedge clk) begin
    r1 <= rom_addr;
    r2 <= r1;
    m1 <= m_rom_addr;
  end
  assign rom_data   = rom_word(r2);
  assign m_rom_data = rom_word(m1);

  sprite_rom_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(12), .DATA_WIDTH(16), .READ_LATENCY(2), .BURST_LEN(8)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en), .req_i(req), .base_addr_i(base_addr),
    .gnt_o(gnt), .rom_en_o(rom_en), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .data_o(data), .data_valid_o(data_valid), .data_last_o(data_last), .busy_o(busy)
  );

  sprite_rom_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(12), .DATA_WIDTH(16), .READ_LATENCY(1), .BURST_LEN(1)
  ) dut_min (
    .clk(clk), .rst(rst), .en_i(m_en), .req_i(m_req), .base_addr_i(m_base_addr),
    .gnt_o(m_gnt), .rom_en_o(m_rom_en), .rom_addr_o(m_rom_addr), .rom_data_i(m_rom_data),
    .data_o(m_data), .data_valid_o(m_data_valid), .data_last_o(m_data_last), .busy_o(m_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if ({gnt, rom_en, rom_addr} !== 17'h0) $display("[TB] FAIL reset_issue: got %h want 0", {gnt, rom_en, rom_addr}); else passed++;
    total++; if ({data, data_valid, data_last} !== 21'h0) $display("[TB] FAIL reset_data: got %h want 0", {data, data_valid, data_last}); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if ({m_gnt, m_rom_en, m_data_valid, m_busy} !== 10'h0) $display("[TB] FAIL reset_min: got %h want 0", {m_gnt, m_rom_en, m_data_valid, m_busy}); else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [3:0]  exp_gnt, exp_dv;
    logic [11:0] exp_addr;
    req = 4'b0010;
    base_addr = {12'h333, 12'h222, 12'h100, 12'h000};
    for (int j = 1; j <= 12; j++) begin
      step();
      if (j == 1) req = '0;
      exp_gnt  = (j == 1) ? 4'b0010 : 4'b0000;
      exp_dv   = (j >= 4 && j <= 11) ? 4'b0010 : 4'b0000;
      exp_addr = 12'h100 + 12'(j - 1);
      total++; if (gnt !== exp_gnt) $display("[TB] FAIL single_gnt c%0d: got %b want %b", j, gnt, exp_gnt); else passed++;
      total++; if (rom_en !== (j <= 8)) $display("[TB] FAIL single_rom_en c%0d: got %b want %b", j, rom_en, j <= 8); else passed++;
      if (j <= 8) begin
        total++; if (rom_addr !== exp_addr) $display("[TB] FAIL single_addr c%0d: got %h want %h", j, rom_addr, exp_addr); else passed++;
      end
      total++; if (data_valid !== exp_dv) $display("[TB] FAIL single_dv c%0d: got %b want %b", j, data_valid, exp_dv); else passed++;
      if (j >= 4 && j <= 11) begin
        total++; if (data !== rom_word(12'h100 + 12'(j - 4))) $display("[TB] FAIL single_data c%0d: got %h want %h", j, data, rom_word(12'h100 + 12'(j - 4))); else passed++;
      end
      total++; if (data_last !== (j == 11)) $display("[TB] FAIL single_last c%0d: got %b want %b", j, data_last, j == 11); else passed++;
      total++; if (busy !== (j <= 11)) $display("[TB] FAIL single_busy c%0d: got %b want %b", j, busy, j <= 11); else passed++;
    end
  endtask

  task automatic test_round_robin();
    int          grant_cyc [5];
    logic [3:0]  grant_val [5];
    int          n = 0;
    bit          idle_seen = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    for (int c = 1; c <= 70 && n < 5; c++) begin
      step();
      if (gnt !== 4'b0000) begin
        grant_cyc[n] = c;
        grant_val[n] = gnt;
        n++;
      end
    end
    req = '0;
    total++; if (n !== 5) $display("[TB] FAIL rr_count: got %0d want 5", n); else passed++;
    for (int i = 0; i < n; i++) begin
      total++; if (grant_val[i] !== (4'b0001 << (i % 4))) $display("[TB] FAIL rr_order #%0d: got %b want %b", i, grant_val[i], 4'b0001 << (i % 4)); else passed++;
      if (i > 0) begin
        total++; if (grant_cyc[i] - grant_cyc[i-1] !== 12) $display("[TB] FAIL rr_spacing #%0d: got %0d want 12", i, grant_cyc[i] - grant_cyc[i-1]); else passed++;
      end
    end
    for (int c = 0; c < 40 && !idle_seen; c++) begin
      step();
      idle_seen = (busy === 1'b0);
    end
    total++; if (!idle_seen) $display("[TB] FAIL rr_idle: got busy=%b want 0 within 40 cycles", busy); else passed++;
  endtask

  task automatic test_wrap();
    logic [11:0] exp_addr;
    req = 4'b0001;
    base_addr = {12'h333, 12'h222, 12'h100, 12'hFFC};
    for (int j = 1; j <= 12; j++) begin
      step();
      if (j == 1) req = '0;
      exp_addr = 12'hFFC + 12'(j - 1);
      if (j <= 8) begin
        total++; if (rom_addr !== exp_addr) $display("[TB] FAIL wrap_addr c%0d: got %h want %h", j, rom_addr, exp_addr); else passed++;
      end
      if (j == 11) begin
        total++; if ({data_valid, data_last} !== 5'b00011) $display("[TB] FAIL wrap_last: got %b want 00011", {data_valid, data_last}); else passed++;
        total++; if (data !== rom_word(12'h003)) $display("[TB] FAIL wrap_data: got %h want %h", data, rom_word(12'h003)); else passed++;
      end
    end
    total++; if (busy !== 1'b0) $display("[TB] FAIL wrap_idle: got %b want 0", busy); else passed++;
  endtask

  task automatic test_abort();
    bit idle_seen = 1'b0;
    req = 4'b0100;
    for (int j = 1; j <= 4; j++) begin
      step();
      if (j == 1) begin
        req = '0;
        total++; if (gnt !== 4'b0100) $display("[TB] FAIL abort_gnt: got %b want 0100", gnt); else passed++;
      end
    end
    total++; if (rom_addr !== 12'h225 || data_valid !== 4'b0100) $display("[TB] FAIL abort_beat3: got addr %h dv %b want 225 0100", rom_addr, data_valid); else passed++;
    en = 1'b0;
    step();
    total++; if ({rom_en, busy, gnt} !== 6'b0) $display("[TB] FAIL abort_stop: got %b want 000000", {rom_en, busy, gnt}); else passed++;
    total++; if ({data_valid, data_last} !== 5'b0) $display("[TB] FAIL abort_flush: got %b want 00000", {data_valid, data_last}); else passed++;
    req = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      step();
      total++; if ({gnt, rom_en, data_valid, data_last} !== 10'b0) $display("[TB] FAIL abort_quiet c%0d: got %b want 0", j, {gnt, rom_en, data_valid, data_last}); else passed++;
    end
    en = 1'b1;
    step();
    req = '0;
    total++; if (gnt !== 4'b1000 || rom_addr !== 12'h333) $display("[TB] FAIL abort_next: got gnt %b addr %h want 1000 333", gnt, rom_addr); else passed++;
    for (int c = 0; c < 40 && !idle_seen; c++) begin
      step();
      idle_seen = (busy === 1'b0);
    end
    total++; if (!idle_seen) $display("[TB] FAIL abort_idle: got busy=%b want 0 within 40 cycles", busy); else passed++;
  endtask

  task automatic test_async_reset();
    bit idle_seen = 1'b0;
    req = 4'b0100;
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j == 1) req = '0;
    end
    total++; if (busy !== 1'b1 || data_valid !== 4'b0100) $display("[TB] FAIL rst_pre: got busy %b dv %b want 1 0100", busy, data_valid); else passed++;
    rst = 1'b1;
    #1;
    total++; if ({gnt, rom_en, rom_addr, busy} !== 18'h0) $display("[TB] FAIL rst_issue: got %h want 0", {gnt, rom_en, rom_addr, busy}); else passed++;
    total++; if ({data, data_valid, data_last} !== 21'h0) $display("[TB] FAIL rst_data: got %h want 0", {data, data_valid, data_last}); else passed++;
    step();
    rst = 1'b0;
    req = 4'b1001;
    step();
    req = '0;
    total++; if (gnt !== 4'b0001) $display("[TB] FAIL rst_first_gnt: got %b want 0001", gnt); else passed++;
    step();
    total++; if (data_valid !== 4'b0000) $display("[TB] FAIL rst_no_data: got %b want 0000", data_valid); else passed++;
    for (int c = 0; c < 40 && !idle_seen; c++) begin
      step();
      idle_seen = (busy === 1'b0);
    end
    total++; if (!idle_seen) $display("[TB] FAIL rst_idle: got busy=%b want 0 within 40 cycles", busy); else passed++;
  endtask

  task automatic test_min_params();
    m_base_addr = {12'h000, 12'h0C3, 12'h000, 12'h3A5};
    m_req = 4'b0101;
    step();
    total++; if ({m_gnt, m_rom_en, m_busy} !== 6'b000111 || m_rom_addr !== 12'h3A5) $display("[TB] FAIL min_grant: got %b addr %h want 000111 3a5", {m_gnt, m_rom_en, m_busy}, m_rom_addr); else passed++;
    step();
    total++; if ({m_rom_en, m_data_valid, m_busy} !== 6'b000001) $display("[TB] FAIL min_gap: got %b want 000001", {m_rom_en, m_data_valid, m_busy}); else passed++;
    step();
    total++; if ({m_data_valid, m_data_last, m_busy} !== 6'b000111) $display("[TB] FAIL min_beat: got %b want 000111", {m_data_valid, m_data_last, m_busy}); else passed++;
    total++; if (m_data !== rom_word(12'h3A5)) $display("[TB] FAIL min_data: got %h want %h", m_data, rom_word(12'h3A5)); else passed++;
    step();
    total++; if ({m_data_valid, m_data_last, m_busy} !== 6'b0) $display("[TB] FAIL min_done: got %b want 000000", {m_data_valid, m_data_last, m_busy}); else passed++;
    step();
    m_req = '0;
    total++; if (m_gnt !== 4'b0100 || m_rom_addr !== 12'h0C3) $display("[TB] FAIL min_next: got gnt %b addr %h want 0100 0c3", m_gnt, m_rom_addr); else passed++;
    step();
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_abort();
    test_async_reset();
    test_min_params();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
